intmatmul_row_sequencer: RTL and testbench

Time-multiplexed integer matrix-vector multiply controller. The host loads an N×N matrix and an N-vector over the global bus, then issues a start command. A finite-state machine then drives one shared multiply-accumulate unit, one element per cycle, row by row, and writes each row result to a result buffer. It replaces N parallel dot-product instances with one MAC, trading latency for area. Busy and done are exposed both as pins and as a bus-readable status word.

---
 rtl/intmatmul_pkg.sv | 32 +++
 rtl/intmatmul_mac_unit.sv | 41 ++++
 rtl/intmatmul_row_sequencer.sv | 176 +++++++++++++++++
 tb/tb_intmatmul_row_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/intmatmul_pkg.sv
// Shared definitions for the integer matrix-vector row sequencer: bus regions,
// FSM encoding and control/status bit positions.
package intmatmul_pkg;

    localparam logic [1:0] REG_MATRIX = 2'd0;
    localparam logic [1:0] REG_VECTOR = 2'd1;
    localparam logic [1:0] REG_RESULT = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int START  = 0;
    localparam int CLRERR = 1;

    localparam int BUSY  = 0;
    localparam int DONE  = 1;
    localparam int WRERR = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        STORE = 2'd2
    } state_e;

    function automatic logic [31:0] status_word(input logic b, input logic d, input logic e);
        logic [31:0] w;
        w        = 32'd0;
        w[BUSY]  = b;
        w[DONE]  = d;
        w[WRERR] = e;
        return w;
    endfunction

endpackage

// File: rtl/intmatmul_mac_unit.sv
// Single shared multiply-accumulate stage; clear_n_i=0 starts a fresh sum
// with the current product, all arithmetic truncated to W bits.
module intmatmul_mac_unit #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         clear_n_i,
    input  logic         en_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] prod_s;

    // next accumulator value
    always_comb begin
        prod_s = a_i * b_i;
        acc_d  = acc_q;
        if (en_i) begin
            acc_d = clear_n_i ? (acc_q + prod_s) : prod_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // accumulator register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/intmatmul_row_sequencer.sv
// Bus-loaded N x N matrix times N-vector, computed row by row on one shared
// MAC; results are buffered and readable over the same bus.
module intmatmul_row_sequencer
    import intmatmul_pkg::*;
#(
    parameter int pVectorSize = 2,
    parameter int pWordSize   = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RD,
    input  logic        WR,
    input  logic [14:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        busy,
    output logic        done
);

    localparam int N  = pVectorSize;
    localparam int W  = pWordSize;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = 13;

    state_e        state_q;
    logic [CW-1:0] r_q;
    logic [CW-1:0] c_q;
    logic          done_q;
    logic          wrerr_q;

    logic [W-1:0]  mat_q [N*N];
    logic [W-1:0]  vec_q [N];
    logic [W-1:0]  res_q [N];

    logic [1:0]    region_s;
    logic [IW-1:0] idx_s;
    logic [IW-1:0] mat_idx_s;
    logic          busy_s;
    logic          wr_mat_s;
    logic          wr_vec_s;
    logic          wr_ctrl_s;
    logic          start_s;
    logic          last_c_s;
    logic          last_r_s;
    logic [W-1:0]  a_s;
    logic [W-1:0]  b_s;
    logic [W-1:0]  acc_s;
    logic [W-1:0]  rd_elem_s;
    logic [31:0]   rd_word_s;
    logic          unused_data_s;

    assign region_s      = Addr[14:13];
    assign idx_s         = Addr[12:0];
    assign busy_s        = (state_q != IDLE);
    assign wr_mat_s      = WR && (region_s == REG_MATRIX);
    assign wr_vec_s      = WR && (region_s == REG_VECTOR);
    assign wr_ctrl_s     = WR && (region_s == REG_CTRL);
    assign start_s       = wr_ctrl_s && DataIn[START] && (state_q == IDLE);
    assign last_c_s      = (c_q == CW'(N - 1));
    assign last_r_s      = (r_q == CW'(N - 1));
    assign mat_idx_s     = IW'(r_q) * IW'(N) + IW'(c_q);
    assign unused_data_s = &{1'b0, DataIn};

    // operand fetch for the current (row, col)
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int k = 0; k < N*N; k++) begin
            a_s = (mat_idx_s == IW'(k)) ? mat_q[k] : a_s;
        end
        for (int k = 0; k < N; k++) begin
            b_s = (c_q == CW'(k)) ? vec_q[k] : b_s;
        end
    end

    intmatmul_mac_unit #(.W(W)) u_mac (
        .clk_i     (Clk),
        .rst_n_i   (Reset),
        .a_i       (a_s),
        .b_i       (b_s),
        .clear_n_i (c_q != '0),
        .en_i      (state_q == MAC),
        .acc_o     (acc_s)
    );

    // sequencing FSM with counters and sticky flags
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            wrerr_q <= 1'b0;
        end else begin
            if (wr_ctrl_s && DataIn[CLRERR]) begin
                wrerr_q <= 1'b0;
            end else if ((wr_mat_s || wr_vec_s) && busy_s) begin
                wrerr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        state_q <= MAC;
                        r_q     <= '0;
                        c_q     <= '0;
                        done_q  <= 1'b0;
                    end
                end
                MAC: begin
                    if (last_c_s) begin
                        state_q <= STORE;
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                STORE: begin
                    c_q <= '0;
                    if (last_r_s) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        r_q     <= r_q + CW'(1);
                        state_q <= MAC;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // operand and result storage; host writes are locked out while running
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int k = 0; k < N*N; k++) mat_q[k] <= '0;
            for (int k = 0; k < N; k++) begin
                vec_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N*N; k++) begin
                if (wr_mat_s && !busy_s && (idx_s == IW'(k))) mat_q[k] <= DataIn[W-1:0];
            end
            for (int k = 0; k < N; k++) begin
                if (wr_vec_s && !busy_s && (idx_s == IW'(k))) vec_q[k] <= DataIn[W-1:0];
                if ((state_q == STORE) && (r_q == CW'(k))) res_q[k] <= acc_s;
            end
        end
    end

    // bus read mux; out-of-range indices fall through to zero
    always_comb begin
        rd_elem_s = '0;
        rd_word_s = 32'd0;
        case (region_s)
            REG_MATRIX: begin
                for (int k = 0; k < N*N; k++) rd_elem_s = (idx_s == IW'(k)) ? mat_q[k] : rd_elem_s;
                rd_word_s = 32'(rd_elem_s);
            end
            REG_VECTOR: begin
                for (int k = 0; k < N; k++) rd_elem_s = (idx_s == IW'(k)) ? vec_q[k] : rd_elem_s;
                rd_word_s = 32'(rd_elem_s);
            end
            REG_RESULT: begin
                for (int k = 0; k < N; k++) rd_elem_s = (idx_s == IW'(k)) ? res_q[k] : rd_elem_s;
                rd_word_s = 32'(rd_elem_s);
            end
            REG_CTRL: rd_word_s = status_word(busy_s, done_q, wrerr_q);
            default:  rd_word_s = 32'd0;
        endcase
    end

    assign DataOut = RD ? rd_word_s : 32'bz;
    assign busy    = busy_s;
    assign done    = done_q;

endmodule

// File: tb/tb_intmatmul_row_sequencer.sv
// Scoreboard bench: stimulus pushes expected read responses computed from a
// behavioural matrix-vector model; a negedge monitor pops and compares.
module tb_intmatmul_row_sequencer;

    localparam int N    = 2;
    localparam int W    = 8;
    localparam int RUN  = N * (N + 1);
    localparam int MASK = (1 << W) - 1;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        RD;
    logic        WR;
    logic [14:0] Addr;
    logic [31:0] DataIn;
    wire  [31:0] DataOut;
    logic        busy;
    logic        done;

    intmatmul_row_sequencer #(.pVectorSize(N), .pWordSize(W)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .RD      (RD),
        .WR      (WR),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .busy    (busy),
        .done    (done)
    );

    always #5 Clk = ~Clk;

    int edge_cnt = 0;
    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    // behavioural model state
    int m_mat [N*N];
    int m_vec [N];
    int m_res_old [N];
    int m_res_new [N];
    bit run_valid;
    int run_t;
    bit m_wrerr;

    typedef struct {
        logic [31:0] data;
        logic        b;
        logic        d;
        string       name;
    } exp_t;
    exp_t sbq [$];
    exp_t mx;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit busy_at(int e);
        return run_valid && (e >= run_t) && (e < run_t + RUN);
    endfunction

    function automatic bit done_at(int e);
        return run_valid && (e >= run_t + RUN);
    endfunction

    function automatic int res_at(int r, int e);
        if (run_valid && (e >= run_t + (r + 1) * (N + 1))) return m_res_new[r];
        return m_res_old[r];
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        RD    = 1'b0;
        WR    = 1'b0;
        tick();
        Reset     = 1'b1;
        run_valid = 1'b0;
        run_t     = 0;
        m_wrerr   = 1'b0;
        for (int k = 0; k < N*N; k++) m_mat[k] = 0;
        for (int k = 0; k < N; k++) begin
            m_vec[k]     = 0;
            m_res_old[k] = 0;
            m_res_new[k] = 0;
        end
    endtask

    task automatic bus_write(input logic [1:0] rg, input int idx, input logic [31:0] d);
        int e;
        bit b;
        e      = edge_cnt;
        b      = busy_at(e);
        WR     = 1'b1;
        Addr   = {rg, 13'(idx)};
        DataIn = d;
        tick();
        WR = 1'b0;
        case (rg)
            2'd0: begin
                if (b) m_wrerr = 1'b1;
                else if (idx < N*N) m_mat[idx] = int'(d) & MASK;
            end
            2'd1: begin
                if (b) m_wrerr = 1'b1;
                else if (idx < N) m_vec[idx] = int'(d) & MASK;
            end
            2'd3: begin
                if (d[1]) m_wrerr = 1'b0;
                if (d[0] && !b) begin
                    for (int r = 0; r < N; r++) begin
                        int s;
                        m_res_old[r] = res_at(r, e);
                        s = 0;
                        for (int c = 0; c < N; c++) s += m_mat[r*N + c] * m_vec[c];
                        m_res_new[r] = s & MASK;
                    end
                    run_t     = e + 1;
                    run_valid = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [1:0] rg, input int idx, input string name);
        int   e;
        exp_t x;
        e = edge_cnt;
        case (rg)
            2'd0: x.data = (idx < N*N) ? 32'(m_mat[idx]) : 32'd0;
            2'd1: x.data = (idx < N) ? 32'(m_vec[idx]) : 32'd0;
            2'd2: x.data = (idx < N) ? 32'(res_at(idx, e)) : 32'd0;
            default: x.data = {29'd0, m_wrerr, done_at(e), busy_at(e)};
        endcase
        x.b    = busy_at(e);
        x.d    = done_at(e);
        x.name = name;
        sbq.push_back(x);
        RD   = 1'b1;
        Addr = {rg, 13'(idx)};
        tick();
        RD = 1'b0;
    endtask

    task automatic load(input int a0, input int a1, input int a2, input int a3,
                        input int v0, input int v1);
        bus_write(2'd0, 0, 32'(a0));
        bus_write(2'd0, 1, 32'(a1));
        bus_write(2'd0, 2, 32'(a2));
        bus_write(2'd0, 3, 32'(a3));
        bus_write(2'd1, 0, 32'(v0));
        bus_write(2'd1, 1, 32'(v1));
    endtask

    // monitor: every read cycle is checked against the oldest expectation
    always @(negedge Clk) begin
        if (RD) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read: got %h want no read", DataOut);
            end else begin
                mx = sbq.pop_front();
                n_cmp++;
                if (DataOut !== mx.data) begin
                    n_bad++;
                    $display("FAIL %s data: got %h want %h", mx.name, DataOut, mx.data);
                end
                n_cmp++;
                if (busy !== mx.b) begin
                    n_bad++;
                    $display("FAIL %s busy_pin: got %b want %b", mx.name, busy, mx.b);
                end
                n_cmp++;
                if (done !== mx.d) begin
                    n_bad++;
                    $display("FAIL %s done_pin: got %b want %b", mx.name, done, mx.d);
                end
            end
        end
    end

    initial begin
        Reset  = 1'b0;
        RD     = 1'b0;
        WR     = 1'b0;
        Addr   = 15'd0;
        DataIn = 32'd0;
        tick();
        do_reset();

        for (int k = 0; k < N*N + 1; k++) bus_read(2'd0, k, "rst_mat");
        for (int k = 0; k < N + 1; k++) bus_read(2'd1, k, "rst_vec");
        for (int k = 0; k < N + 1; k++) bus_read(2'd2, k, "rst_res");
        bus_read(2'd3, 0, "rst_status");

        // directed 2x2 run with cycle-by-cycle status polling
        load(1, 2, 3, 4, 5, 6);
        bus_write(2'd3, 0, 32'h1);
        for (int i = 0; i < RUN + 2; i++) bus_read(2'd3, 0, "run_status");
        bus_read(2'd2, 0, "res0_17");
        bus_read(2'd2, 1, "res1_39");

        // truncation modulo 2^W
        load(200, 200, 7, 9, 2, 1);
        bus_write(2'd3, 0, 32'h1);
        idle(RUN);
        bus_read(2'd2, 0, "ovf_res0");
        bus_read(2'd2, 1, "ovf_res1");
        bus_read(2'd3, 0, "ovf_status");

        // write during run sets wrerr and does not disturb the run
        load(3, 1, 4, 1, 5, 9);
        bus_write(2'd3, 0, 32'h1);
        idle(1);
        bus_write(2'd0, 0, 32'd77);
        idle(RUN);
        bus_read(2'd3, 0, "wrerr_status");
        bus_read(2'd2, 0, "wrerr_res0");
        bus_read(2'd2, 1, "wrerr_res1");
        bus_read(2'd0, 0, "wrerr_mat0");
        bus_write(2'd3, 0, 32'h2);
        bus_read(2'd3, 0, "clrerr_status");

        // start while busy is ignored; out-of-range writes are dropped
        bus_write(2'd3, 0, 32'h1);
        idle(1);
        bus_write(2'd3, 0, 32'h1);
        for (int i = 0; i < RUN; i++) bus_read(2'd3, 0, "restart_status");
        bus_write(2'd1, 5, 32'd99);
        bus_read(2'd1, 5, "oor_vec5");
        bus_read(2'd3, 0, "oor_status");

        // randomized runs
        for (int it = 0; it < 10; it++) begin
            load($urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, MASK),
                 $urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, MASK));
            bus_write(2'd3, 0, 32'h1);
            for (int i = 0; i < RUN; i++) begin
                if ($urandom_range(0, 1) == 0) bus_read(2'd3, 0, "rnd_status");
                else bus_read(2'd0, $urandom_range(0, N*N), "rnd_mat");
            end
            bus_read(2'd2, 0, "rnd_res0");
            bus_read(2'd2, 1, "rnd_res1");
            bus_read(2'd3, 0, "rnd_done");
        end

        // reset in the middle of a run
        load(9, 8, 7, 6, 5, 4);
        bus_write(2'd3, 0, 32'h1);
        idle(3);
        do_reset();
        bus_read(2'd3, 0, "midrst_status");
        bus_read(2'd2, 0, "midrst_res0");
        bus_read(2'd2, 1, "midrst_res1");
        bus_read(2'd0, 0, "midrst_mat0");
        bus_read(2'd1, 1, "midrst_vec1");

        idle(2);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
